snn_layer_core: RTL
===================

Name: snn_layer_core

Overview:
- Time-multiplexed leaky integrate-and-fire layer: NUM_NEURONS neurons share one input stream of NUM_INPUTS synapses.
- Each neuron has its own programmable weight bank, threshold comparison, shift-based leak and refractory counter.
- Generalises the single-neuron core to a multi-neuron layer, emitting a spike vector per inference tick.
- Sits between the input-frame buffer (addressed via input_read_addr) and the downstream spike router.

Parameters:
- NUM_INPUTS, 256, synapses per neuron (power of 2, >=2)
- NUM_NEURONS, 4, neurons in the layer (>=1)
- INPUT_W, 8, unsigned input sample width
- WEIGHT_W, 8, signed weight width
- POT_W, 24, signed membrane potential width
- REFR_W, 4, refractory counter width

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- program_mode  in  1  enables weight writes, blocks start_tick
- prog_neuron  in  clog2(NUM_NEURONS) (min 1)  target neuron for write
- prog_addr  in  clog2(NUM_INPUTS)  target synapse
- prog_data  in  WEIGHT_W signed  weight value
- prog_wr_en  in  1  write strobe
- threshold  in  POT_W signed  fire threshold, latched on accepted start_tick
- leak_shift  in  4  leak shift, latched on accepted start_tick; 0 = no leak
- refractory  in  REFR_W  refractory ticks after fire, latched on accepted start_tick
- start_tick  in  1  begin one inference tick
- current_input_val  in  INPUT_W  sample at input_read_addr, combinational from addr
- input_read_addr  out  clog2(NUM_INPUTS)  synapse index being read
- spikes  out  NUM_NEURONS  one-cycle fire pulses
- tick_done  out  1  one-cycle pulse, coincident with spikes
- busy  out  1  high from ACCUM through UPDATE
- monitor_sel  in  clog2(NUM_NEURONS) (min 1)  neuron to monitor
- monitor_potential  out  POT_W signed  potential of monitor_sel neuron, combinational mux

Behaviour:
- Reset: state IDLE; busy, spikes, tick_done, input_read_addr = 0; all potentials, accumulators, refractory counters and weights = 0.
- Weight write: on a clk edge with program_mode && prog_wr_en && !busy, weight[prog_neuron][prog_addr] <= prog_data. Ignored while busy. Out-of-range prog_neuron is ignored.
- State IDLE:
  - start_tick && !program_mode latches config, clears accumulators, sets idx = 0, moves to ACCUM.
  - start_tick while busy or in program_mode is ignored.
- State ACCUM, one synapse per cycle:
  - input_read_addr = idx.
  - acc[n] += signed({0, current_input_val}) * weight[n][idx] for all n in parallel.
  - Accumulator width is INPUT_W + WEIGHT_W + 1 + clog2(NUM_INPUTS), so it cannot overflow.
  - When idx == NUM_INPUTS-1, move to UPDATE. The address does not wrap beyond this.
- State UPDATE, one cycle, per neuron:
  - If refr[n] != 0: refr[n]--, potential held, acc discarded, no fire.
  - Else: leaked = (leak_shift == 0) ? pot : pot - (pot >>> leak_shift); new = sat_POT_W(leaked + acc).
  - If new >= threshold: spike, pot <= 0, refr <= refractory.
  - Else: pot <= new.
  - Saturation clamps to [-2^(POT_W-1), 2^(POT_W-1)-1].
  - Next state IDLE.
- Outputs and latency:
  - spikes and tick_done are registered and pulse for exactly one cycle, the cycle after UPDATE.
  - busy is high for exactly NUM_INPUTS+1 cycles.
  - If start_tick is accepted at edge k, tick_done is high in cycle k+NUM_INPUTS+2, and busy is already 0 in that cycle.
  - A new start_tick is accepted in that same cycle.
- Reset asserted mid-tick aborts immediately to reset values. No partial spikes are emitted.

Decomposition:
- snn_pkg holds:
  - state enum (IDLE, ACCUM, UPDATE)
  - accumulator-width function
  - saturating-add function
  - default widths
- Sub-module lif_neuron_unit holds one neuron's accumulator, potential, refractory counter and update/fire logic. It is instantiated NUM_NEURONS times via generate. The top level owns the FSM, index counter, weight banks and monitor mux.

Test Plan:
- All weights 2, input 128, threshold 100000, leak 0, refractory 0 -> every neuron's potential is 65536 after tick 0 (no spike), then spikes = 4'b1111 on tick 1, then potential 0.
- Same setup with refractory 2 -> fire at tick 1; ticks 2 and 3 hold potential 0 with no spike; tick 4 gives potential 65536.
- Weights 1, input 128, leak_shift 1, threshold 60000 -> potentials 32768, 49152, 57344, then spike on tick 3 (pre-fire value 61440).
- Neuron 0 weights -128, input 255 -> -8355840 after tick 0, saturates to -8388608 after tick 1. Neuron 1 weights 0 stays at 0 with spikes[1] = 0. The other neurons are programmed +2 and fire normally.
- start_tick at edge k -> busy for 257 cycles, tick_done single pulse in cycle k+258; a second start_tick during busy is ignored; prog_wr_en during busy leaves the weight unchanged.
- rst_n low at idx 100 -> busy 0 at once; potentials, weights and spikes are 0; the next tick after reprogramming behaves as in scenario 1.

Source files
------------

// File: rtl/snn_pkg.sv
// Shared types, default widths and arithmetic helpers for the spiking layer.
// Latency: none (package only).
// Backpressure: none (package only).
package snn_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCUM  = 2'd1,
        UPDATE = 2'd2
    } state_t;

    localparam int DEF_NUM_INPUTS  = 256;
    localparam int DEF_NUM_NEURONS = 4;
    localparam int DEF_INPUT_W     = 8;
    localparam int DEF_WEIGHT_W    = 8;
    localparam int DEF_POT_W       = 24;
    localparam int DEF_REFR_W      = 4;

    // Wide enough for NUM_INPUTS worst-case products of an unsigned sample
    // (zero-extended to signed) and a signed weight, so it can never overflow.
    function automatic int acc_width(input int in_w, input int wt_w, input int n_in);
        return in_w + wt_w + 1 + $clog2(n_in);
    endfunction

    // Adds two sign-extended operands and clamps the sum to a w-bit signed range.
    // Operands are far smaller than 64 bits, so the raw sum itself cannot wrap.
    function automatic logic signed [63:0] sat_add(input logic signed [63:0] a,
                                                   input logic signed [63:0] b,
                                                   input int w);
        logic signed [63:0] s;
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        logic signed [63:0] res;
        s  = a + b;
        hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (w - 1));
        if (s > hi)
            res = hi;
        else if (s < lo)
            res = lo;
        else
            res = s;
        return res;
    endfunction

endpackage

// File: rtl/lif_neuron_unit.sv
// One leaky integrate-and-fire neuron: accumulator, membrane potential, refractory counter, fire.
// Latency: accumulates one product per i_acc_en cycle; o_spike is registered, one cycle after i_update.
// Backpressure: none; strobes from the layer FSM are obeyed unconditionally.
// Ports: i_clear zeroes the accumulator, i_acc_en adds sample*weight, i_update applies leak/acc/fire
// using the latched i_threshold/i_leak_shift/i_refractory; o_spike pulse, o_potential current potential.
module lif_neuron_unit
    import snn_pkg::*;
#(
    parameter int INPUT_W  = DEF_INPUT_W,
    parameter int WEIGHT_W = DEF_WEIGHT_W,
    parameter int POT_W    = DEF_POT_W,
    parameter int REFR_W   = DEF_REFR_W,
    parameter int ACC_W    = acc_width(DEF_INPUT_W, DEF_WEIGHT_W, DEF_NUM_INPUTS)
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       i_clear,
    input  logic                       i_acc_en,
    input  logic                       i_update,
    input  logic [INPUT_W-1:0]         i_sample,
    input  logic signed [WEIGHT_W-1:0] i_weight,
    input  logic signed [POT_W-1:0]    i_threshold,
    input  logic [3:0]                 i_leak_shift,
    input  logic [REFR_W-1:0]          i_refractory,
    output logic                       o_spike,
    output logic signed [POT_W-1:0]    o_potential
);

    localparam int PROD_W = INPUT_W + WEIGHT_W + 1;

    logic signed [ACC_W-1:0]  r_acc;
    logic signed [POT_W-1:0]  r_pot;
    logic [REFR_W-1:0]        r_refr;
    logic                     r_spike;

    logic signed [PROD_W-1:0] w_sample_ext;
    logic signed [PROD_W-1:0] w_weight_ext;
    logic signed [PROD_W-1:0] w_product;
    logic signed [ACC_W-1:0]  w_prod_ext;
    logic signed [63:0]       w_pot_ext;
    logic signed [63:0]       w_acc_ext;
    logic signed [63:0]       w_thr_ext;
    logic signed [63:0]       w_leaked;
    logic signed [63:0]       w_new;
    logic                     w_fire;

    // Sample is unsigned: zero-extend before the signed multiply. The true
    // product always fits in PROD_W bits, so the truncated result is exact.
    assign w_sample_ext = $signed({{(WEIGHT_W + 1){1'b0}}, i_sample});
    assign w_weight_ext = {{(PROD_W - WEIGHT_W){i_weight[WEIGHT_W-1]}}, i_weight};
    assign w_product    = w_sample_ext * w_weight_ext;
    assign w_prod_ext   = {{(ACC_W - PROD_W){w_product[PROD_W-1]}}, w_product};

    assign w_pot_ext = {{(64 - POT_W){r_pot[POT_W-1]}}, r_pot};
    assign w_acc_ext = {{(64 - ACC_W){r_acc[ACC_W-1]}}, r_acc};
    assign w_thr_ext = {{(64 - POT_W){i_threshold[POT_W-1]}}, i_threshold};

    // Shift of zero means "no leak" rather than "leak everything".
    assign w_leaked = (i_leak_shift == 4'd0) ? w_pot_ext
                                             : w_pot_ext - (w_pot_ext >>> i_leak_shift);
    assign w_new    = sat_add(w_leaked, w_acc_ext, POT_W);
    assign w_fire   = (w_new >= w_thr_ext);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc   <= '0;
            r_pot   <= '0;
            r_refr  <= '0;
            r_spike <= 1'b0;
        end else begin
            r_spike <= 1'b0;
            if (i_clear)
                r_acc <= '0;
            else if (i_acc_en)
                r_acc <= r_acc + w_prod_ext;

            if (i_update) begin
                // A refractory neuron holds its potential and drops this tick's input.
                if (r_refr != '0) begin
                    r_refr <= r_refr - REFR_W'(1);
                end else if (w_fire) begin
                    r_spike <= 1'b1;
                    r_pot   <= '0;
                    r_refr  <= i_refractory;
                end else begin
                    r_pot <= w_new[POT_W-1:0];
                end
            end
        end
    end

    assign o_spike     = r_spike;
    assign o_potential = r_pot;

endmodule

// File: rtl/snn_layer_core.sv
// Time-multiplexed LIF layer: NUM_NEURONS neurons integrate one shared input stream, one synapse per cycle.
// Latency: start_tick accepted at edge k -> busy k+1..k+NUM_INPUTS+1, spikes/tick_done pulse in cycle k+NUM_INPUTS+2.
// Backpressure: start_tick and weight writes are dropped (not queued) while busy; start_tick also dropped in program_mode.
// Ports: program_mode/prog_* write weights while idle; threshold/leak_shift/refractory latched on start;
// input_read_addr/current_input_val read the frame buffer; spikes/tick_done results; monitor_sel/monitor_potential debug.
module snn_layer_core
    import snn_pkg::*;
#(
    parameter int NUM_INPUTS  = DEF_NUM_INPUTS,
    parameter int NUM_NEURONS = DEF_NUM_NEURONS,
    parameter int INPUT_W     = DEF_INPUT_W,
    parameter int WEIGHT_W    = DEF_WEIGHT_W,
    parameter int POT_W       = DEF_POT_W,
    parameter int REFR_W      = DEF_REFR_W,
    localparam int ADDR_W     = $clog2(NUM_INPUTS),
    localparam int NEUR_W     = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       program_mode,
    input  logic [NEUR_W-1:0]          prog_neuron,
    input  logic [ADDR_W-1:0]          prog_addr,
    input  logic signed [WEIGHT_W-1:0] prog_data,
    input  logic                       prog_wr_en,
    input  logic signed [POT_W-1:0]    threshold,
    input  logic [3:0]                 leak_shift,
    input  logic [REFR_W-1:0]          refractory,
    input  logic                       start_tick,
    input  logic [INPUT_W-1:0]         current_input_val,
    output logic [ADDR_W-1:0]          input_read_addr,
    output logic [NUM_NEURONS-1:0]     spikes,
    output logic                       tick_done,
    output logic                       busy,
    input  logic [NEUR_W-1:0]          monitor_sel,
    output logic signed [POT_W-1:0]    monitor_potential
);

    localparam int ACC_W = acc_width(INPUT_W, WEIGHT_W, NUM_INPUTS);

    state_t                      r_state;
    logic [ADDR_W-1:0]           r_idx;
    logic                        r_busy;
    logic                        r_tick_done;
    logic signed [POT_W-1:0]     r_threshold;
    logic [3:0]                  r_leak_shift;
    logic [REFR_W-1:0]           r_refractory;
    logic signed [WEIGHT_W-1:0]  r_weight [NUM_NEURONS][NUM_INPUTS];

    logic                        w_start;
    logic                        w_wr;
    logic [NUM_NEURONS-1:0]      w_spike;
    logic signed [POT_W-1:0]     w_pot [NUM_NEURONS];

    assign w_start = (r_state == IDLE) && start_tick && !program_mode;
    assign w_wr    = program_mode && prog_wr_en && !r_busy &&
                     (int'(prog_neuron) < NUM_NEURONS);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_idx        <= '0;
            r_busy       <= 1'b0;
            r_tick_done  <= 1'b0;
            r_threshold  <= '0;
            r_leak_shift <= '0;
            r_refractory <= '0;
        end else begin
            r_tick_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_start) begin
                        r_threshold  <= threshold;
                        r_leak_shift <= leak_shift;
                        r_refractory <= refractory;
                        r_idx        <= '0;
                        r_busy       <= 1'b1;
                        r_state      <= ACCUM;
                    end
                end
                ACCUM: begin
                    // Address parks on the last synapse rather than wrapping.
                    if (r_idx == ADDR_W'(NUM_INPUTS - 1))
                        r_state <= UPDATE;
                    else
                        r_idx <= r_idx + ADDR_W'(1);
                end
                UPDATE: begin
                    r_busy      <= 1'b0;
                    r_tick_done <= 1'b1;
                    r_state     <= IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int n = 0; n < NUM_NEURONS; n++)
                for (int a = 0; a < NUM_INPUTS; a++)
                    r_weight[n][a] <= '0;
        end else if (w_wr) begin
            r_weight[prog_neuron][prog_addr] <= prog_data;
        end
    end

    for (genvar g = 0; g < NUM_NEURONS; g++) begin : g_neuron
        lif_neuron_unit #(
            .INPUT_W  (INPUT_W),
            .WEIGHT_W (WEIGHT_W),
            .POT_W    (POT_W),
            .REFR_W   (REFR_W),
            .ACC_W    (ACC_W)
        ) u_neuron (
            .clk          (clk),
            .rst_n        (rst_n),
            .i_clear      (w_start),
            .i_acc_en     (r_state == ACCUM),
            .i_update     (r_state == UPDATE),
            .i_sample     (current_input_val),
            .i_weight     (r_weight[g][r_idx]),
            .i_threshold  (r_threshold),
            .i_leak_shift (r_leak_shift),
            .i_refractory (r_refractory),
            .o_spike      (w_spike[g]),
            .o_potential  (w_pot[g])
        );
    end

    always_comb begin
        monitor_potential = '0;
        for (int n = 0; n < NUM_NEURONS; n++)
            if (monitor_sel == NEUR_W'(n))
                monitor_potential = w_pot[n];
    end

    assign input_read_addr = r_idx;
    assign spikes          = w_spike;
    assign tick_done       = r_tick_done;
    assign busy            = r_busy;

endmodule
